// File: rtl/mdio_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mdio_pkg
// Shared Clause 22 MDIO definitions used by the PHY-side responder and the
// station-manager side: start/opcode codes, standard register addresses and
// the responder frame-parser state encoding.
// ---------------------------------------------------------------------------
package mdio_pkg;

    localparam logic [1:0]  MDIO_ST        = 2'b01;
    localparam logic [1:0]  MDIO_OP_READ   = 2'b10;
    localparam logic [1:0]  MDIO_OP_WRITE  = 2'b01;

    localparam logic [4:0]  MDIO_REG_BMCR   = 5'd0;
    localparam logic [4:0]  MDIO_REG_BMSR   = 5'd1;
    localparam logic [4:0]  MDIO_REG_PHYID1 = 5'd2;
    localparam logic [4:0]  MDIO_REG_PHYID2 = 5'd3;
    localparam logic [4:0]  MDIO_REG_ANAR   = 5'd4;

    // BMCR.15 is the self-clearing soft-reset bit.
    localparam logic [15:0] BMCR_RESET_BIT  = 16'h8000;

    typedef enum logic [2:0] {
        S_PREAMBLE = 3'd0,
        S_ST       = 3'd1,
        S_OP       = 3'd2,
        S_PHYAD    = 3'd3,
        S_REGAD    = 3'd4,
        S_TA       = 3'd5,
        S_WDATA    = 3'd6,
        S_RDATA    = 3'd7
    } mdio_state_e;

    function automatic logic mdio_op_valid(input logic [1:0] op);
        return (op == MDIO_OP_READ) || (op == MDIO_OP_WRITE);
    endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mdio_sync_edge
// Two-flop synchronizer for an asynchronous MDIO-side signal plus a rising
// edge detector on the synchronized value. Flops reset to 1 so an idle-high
// line never produces a spurious edge when reset is released.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   i_async in   asynchronous input (MDC or MDIO pad)
//   o_sync  out  synchronized level
//   o_rise  out  one-clk pulse on a synchronized 0->1 transition
// ---------------------------------------------------------------------------
module mdio_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/phy_mdio_responder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// phy_mdio_responder
// Clause 22 MDIO slave for a PHY. Oversamples MDC/MDIO with clk, parses
// preamble/ST/OP/PHYAD/REGAD/TA/DATA on each detected MDC rising edge,
// serves reads of registers 0-4 and commits writes to BMCR (0) and ANAR (4).
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   phy_mdc      in   MDC from station manager (asynchronous)
//   mdio_i       in   MDIO pad input
//   mdio_o       out  MDIO drive value
//   mdio_oe      out  MDIO output enable (1 = drive)
//   cfg_bmcr     out  current register 0 contents
//   reg_wr_pulse out  one-clk strobe per committed write
//   reg_wr_addr  out  register address of the committed write
//   reg_wr_data  out  data of the committed write
// ---------------------------------------------------------------------------
module phy_mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'h01,
    parameter int          PREAMBLE_LEN = 32,
    parameter logic [15:0] REG0_DEF     = 16'h1140,
    parameter logic [15:0] REG1_DEF     = 16'h7809,
    parameter logic [15:0] REG2_DEF     = 16'h0022,
    parameter logic [15:0] REG3_DEF     = 16'h1622,
    parameter logic [15:0] REG4_DEF     = 16'h01E1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        phy_mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic [15:0] cfg_bmcr,
    output logic        reg_wr_pulse,
    output logic [4:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data
);

    localparam int               PRE_W    = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PRE_W-1:0] PRE_FULL = PRE_W'(PREAMBLE_LEN);
    localparam logic [15:0]      REG0_RST = REG0_DEF & ~BMCR_RESET_BIT;

    logic        w_mdc_sync;
    logic        w_mdc_rise;
    logic        w_mdio_sync;
    logic        w_mdio_rise;
    logic        w_unused;

    mdio_sync_edge u_mdc_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (phy_mdc),
        .o_sync  (w_mdc_sync),
        .o_rise  (w_mdc_rise)
    );

    mdio_sync_edge u_mdio_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (mdio_i),
        .o_sync  (w_mdio_sync),
        .o_rise  (w_mdio_rise)
    );

    // Only the MDC edge and the MDIO level are needed.
    assign w_unused = &{1'b0, w_mdc_sync, w_mdio_rise};

    mdio_state_e      r_state,   w_state_nxt;
    logic [4:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [PRE_W-1:0] r_pre_cnt, w_pre_cnt_nxt;
    logic [15:0]      r_shift,   w_shift_nxt;
    logic             r_is_read, w_is_read_nxt;
    logic [4:0]       r_regad,   w_regad_nxt;
    logic [15:0]      r_rdata,   w_rdata_nxt;
    logic             r_mdio_oe, w_mdio_oe_nxt;
    logic             r_mdio_o,  w_mdio_o_nxt;
    logic [15:0]      r_reg0,    w_reg0_nxt;
    logic [15:0]      r_reg4,    w_reg4_nxt;
    logic             r_wr_pulse, w_wr_pulse_nxt;
    logic [4:0]       r_wr_addr,  w_wr_addr_nxt;
    logic [15:0]      r_wr_data,  w_wr_data_nxt;
    logic [15:0]      w_shift_in;

    assign w_shift_in = {r_shift[14:0], w_mdio_sync};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_PREAMBLE;
            r_bit_cnt  <= '0;
            r_pre_cnt  <= '0;
            r_shift    <= '0;
            r_is_read  <= 1'b0;
            r_regad    <= '0;
            r_rdata    <= '0;
            r_mdio_oe  <= 1'b0;
            r_mdio_o   <= 1'b0;
            r_reg0     <= REG0_RST;
            r_reg4     <= REG4_DEF;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_pre_cnt  <= w_pre_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_is_read  <= w_is_read_nxt;
            r_regad    <= w_regad_nxt;
            r_rdata    <= w_rdata_nxt;
            r_mdio_oe  <= w_mdio_oe_nxt;
            r_mdio_o   <= w_mdio_o_nxt;
            r_reg0     <= w_reg0_nxt;
            r_reg4     <= w_reg4_nxt;
            r_wr_pulse <= w_wr_pulse_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_pre_cnt_nxt  = r_pre_cnt;
        w_shift_nxt    = r_shift;
        w_is_read_nxt  = r_is_read;
        w_regad_nxt    = r_regad;
        w_rdata_nxt    = r_rdata;
        w_mdio_oe_nxt  = r_mdio_oe;
        w_mdio_o_nxt   = r_mdio_o;
        w_reg0_nxt     = r_reg0;
        w_reg4_nxt     = r_reg4;
        w_wr_pulse_nxt = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;

        if (w_mdc_rise) begin
            w_shift_nxt = w_shift_in;
            case (r_state)
                S_PREAMBLE: begin
                    if (w_mdio_sync) begin
                        if (r_pre_cnt != PRE_FULL) begin
                            w_pre_cnt_nxt = r_pre_cnt + 1'b1;
                        end
                    end else if (r_pre_cnt == PRE_FULL) begin
                        // This 0 is the first ST bit.
                        w_state_nxt   = S_ST;
                        w_pre_cnt_nxt = '0;
                    end else begin
                        w_pre_cnt_nxt = '0;
                    end
                end

                S_ST: begin
                    w_bit_cnt_nxt = '0;
                    if ({1'b0, w_mdio_sync} == MDIO_ST) begin
                        w_state_nxt = S_OP;
                    end else begin
                        w_state_nxt = S_PREAMBLE;
                    end
                end

                S_OP: begin
                    if (r_bit_cnt == 5'd1) begin
                        w_bit_cnt_nxt = '0;
                        w_is_read_nxt = (w_shift_in[1:0] == MDIO_OP_READ);
                        if (mdio_op_valid(w_shift_in[1:0])) begin
                            w_state_nxt = S_PHYAD;
                        end else begin
                            w_state_nxt = S_PREAMBLE;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end
                end

                S_PHYAD: begin
                    if (r_bit_cnt == 5'd4) begin
                        w_bit_cnt_nxt = '0;
                        if (w_shift_in[4:0] == PHY_ADDR) begin
                            w_state_nxt = S_REGAD;
                        end else begin
                            w_state_nxt = S_PREAMBLE;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end
                end

                S_REGAD: begin
                    if (r_bit_cnt == 5'd4) begin
                        w_bit_cnt_nxt = '0;
                        w_regad_nxt   = w_shift_in[4:0];
                        w_state_nxt   = S_TA;
                        // Snapshot read data now so it is stable for the
                        // whole serialization.
                        case (w_shift_in[4:0])
                            MDIO_REG_BMCR:   w_rdata_nxt = r_reg0;
                            MDIO_REG_BMSR:   w_rdata_nxt = REG1_DEF;
                            MDIO_REG_PHYID1: w_rdata_nxt = REG2_DEF;
                            MDIO_REG_PHYID2: w_rdata_nxt = REG3_DEF;
                            MDIO_REG_ANAR:   w_rdata_nxt = r_reg4;
                            default:         w_rdata_nxt = 16'h0000;
                        endcase
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end
                end

                S_TA: begin
                    if (r_bit_cnt == 5'd0) begin
                        w_bit_cnt_nxt = 5'd1;
                        if (r_is_read) begin
                            // Drive the second turnaround bit low.
                            w_mdio_oe_nxt = 1'b1;
                            w_mdio_o_nxt  = 1'b0;
                        end
                    end else begin
                        w_bit_cnt_nxt = '0;
                        if (r_is_read) begin
                            w_mdio_o_nxt = r_rdata[15];
                            w_rdata_nxt  = {r_rdata[14:0], 1'b0};
                            w_state_nxt  = S_RDATA;
                        end else begin
                            w_state_nxt  = S_WDATA;
                        end
                    end
                end

                S_RDATA: begin
                    // Edge k samples D(15-k); the bit after it is already
                    // at the top of the shifted read register.
                    if (r_bit_cnt == 5'd15) begin
                        w_bit_cnt_nxt = '0;
                        w_mdio_oe_nxt = 1'b0;
                        w_mdio_o_nxt  = 1'b0;
                        w_state_nxt   = S_PREAMBLE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                        w_mdio_o_nxt  = r_rdata[15];
                        w_rdata_nxt   = {r_rdata[14:0], 1'b0};
                    end
                end

                S_WDATA: begin
                    if (r_bit_cnt == 5'd15) begin
                        w_bit_cnt_nxt  = '0;
                        w_state_nxt    = S_PREAMBLE;
                        w_wr_pulse_nxt = 1'b1;
                        w_wr_addr_nxt  = r_regad;
                        w_wr_data_nxt  = w_shift_in;
                        if (r_regad == MDIO_REG_BMCR) begin
                            if (w_shift_in[15]) begin
                                w_reg0_nxt = REG0_RST;
                                w_reg4_nxt = REG4_DEF;
                            end else begin
                                w_reg0_nxt = w_shift_in & ~BMCR_RESET_BIT;
                            end
                        end else if (r_regad == MDIO_REG_ANAR) begin
                            w_reg4_nxt = w_shift_in;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end
                end

                default: begin
                    w_state_nxt = S_PREAMBLE;
                end
            endcase
        end
    end

    assign mdio_o       = r_mdio_o;
    assign mdio_oe      = r_mdio_oe;
    assign cfg_bmcr     = r_reg0;
    assign reg_wr_pulse = r_wr_pulse;
    assign reg_wr_addr  = r_wr_addr;
    assign reg_wr_data  = r_wr_data;

endmodule

// File: tb/tb_phy_mdio_responder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_phy_mdio_responder
// Station-manager model driving Clause 22 frames over an open-drain MDIO
// line (25 MHz clk, 2.5 MHz MDC). Expected writes and read data are queued
// from a register-level model; independent monitors compare them against
// reg_wr_* strobes and the bits the PHY puts on the line.
// ---------------------------------------------------------------------------
module tb_phy_mdio_responder;

    localparam logic [4:0]  PHY = 5'h01;
    localparam logic [15:0] D0  = 16'h1140;
    localparam logic [15:0] D1  = 16'h7809;
    localparam logic [15:0] D2  = 16'h0022;
    localparam logic [15:0] D3  = 16'h1622;
    localparam logic [15:0] D4  = 16'h01E1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mdc = 1'b0;
    logic        st_pull = 1'b0;
    logic        mdio_o;
    logic        mdio_oe;
    logic [15:0] cfg_bmcr;
    logic        reg_wr_pulse;
    logic [4:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;
    wire         line = ~((mdio_oe & ~mdio_o) | st_pull);

    phy_mdio_responder #(
        .PHY_ADDR     (PHY),
        .PREAMBLE_LEN (32),
        .REG0_DEF     (D0),
        .REG1_DEF     (D1),
        .REG2_DEF     (D2),
        .REG3_DEF     (D3),
        .REG4_DEF     (D4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .phy_mdc      (mdc),
        .mdio_i       (line),
        .mdio_o       (mdio_o),
        .mdio_oe      (mdio_oe),
        .cfg_bmcr     (cfg_bmcr),
        .reg_wr_pulse (reg_wr_pulse),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;

    int          n_vec = 0;
    int          n_err = 0;
    wr_t         exp_wr_q[$];
    logic [15:0] exp_rd_q[$];
    logic [15:0] m_reg0;
    logic [15:0] m_reg4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register-level reference model.
    function automatic logic [15:0] model_read(input logic [4:0] a);
        case (a)
            5'd0:    return m_reg0;
            5'd1:    return D1;
            5'd2:    return D2;
            5'd3:    return D3;
            5'd4:    return m_reg4;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [15:0] d);
        if (a == 5'd0) begin
            if (d[15]) begin
                m_reg0 = D0;
                m_reg4 = D4;
            end else begin
                m_reg0 = {1'b0, d[14:0]};
            end
        end else if (a == 5'd4) begin
            m_reg4 = d;
        end
    endtask

    task automatic model_reset();
        m_reg0 = D0;
        m_reg4 = D4;
    endtask

    // Station drives on MDC low; the line is released for a 1.
    task automatic send_bit(input logic b);
        mdc = 1'b0;
        st_pull = ~b;
        #200;
        mdc = 1'b1;
        #200;
    endtask

    task automatic frame(input bit rd, input logic [4:0] phy, input logic [4:0] ra,
                         input logic [15:0] wd, input int pre, input int abort_at);
        wr_t w;
        bit  hit;
        hit = (phy == PHY) && (pre >= 32);
        if (hit) begin
            if (rd) begin
                exp_rd_q.push_back(model_read(ra));
            end else begin
                w.a = ra;
                w.d = wd;
                exp_wr_q.push_back(w);
                model_write(ra, wd);
            end
        end
        repeat (pre) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(rd ? 1'b1 : 1'b0);
        send_bit(rd ? 1'b0 : 1'b1);
        for (int i = 4; i >= 0; i--) send_bit(phy[i]);
        for (int i = 4; i >= 0; i--) send_bit(ra[i]);
        if (rd) begin
            send_bit(1'b1);
            send_bit(1'b1);
            for (int i = 0; i < 16; i++) begin
                if (i == abort_at) begin
                    mdc = 1'b0;
                    st_pull = 1'b0;
                    #100;
                    rst_n = 1'b0;
                    #1;
                    check("rst_mid_oe", {31'd0, mdio_oe}, 32'd0);
                    check("rst_mid_wr_pulse", {31'd0, reg_wr_pulse}, 32'd0);
                    model_reset();
                    check("rst_mid_cfg_bmcr", {16'd0, cfg_bmcr}, {16'd0, m_reg0});
                    #200;
                    rst_n = 1'b1;
                    #200;
                    return;
                end
                send_bit(1'b1);
            end
        end else begin
            send_bit(1'b1);
            send_bit(1'b0);
            for (int i = 15; i >= 0; i--) send_bit(wd[i]);
        end
        st_pull = 1'b0;
        #400;
        check("cfg_bmcr", {16'd0, cfg_bmcr}, {16'd0, m_reg0});
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && reg_wr_pulse) begin
            if (exp_wr_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: addr %0d data %h, none required", reg_wr_addr, reg_wr_data);
            end else begin
                check("wr_addr", {27'd0, reg_wr_addr}, {27'd0, exp_wr_q[0].a});
                check("wr_data", {16'd0, reg_wr_data}, {16'd0, exp_wr_q[0].d});
                void'(exp_wr_q.pop_front());
            end
        end
    end

    // Read monitor: once the PHY drives, capture TA2 plus 16 data bits as the
    // station samples them on MDC rising edges.
    initial begin : rd_mon
        logic [16:0] bits;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst_n && mdio_oe) begin
                aborted = 1'b0;
                bits = '0;
                for (int i = 0; i < 17; i++) begin
                    @(posedge mdc or negedge rst_n);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    bits[16-i] = line;
                end
                if (aborted) begin
                    if (exp_rd_q.size() > 0) void'(exp_rd_q.pop_front());
                end else begin
                    repeat (6) @(negedge clk);
                    check("rd_oe_release", {31'd0, mdio_oe}, 32'd0);
                    check("rd_ta2_low", {31'd0, bits[16]}, 32'd0);
                    if (exp_rd_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_read: data %h, no read required", bits[15:0]);
                    end else begin
                        check("rd_data", {16'd0, bits[15:0]}, {16'd0, exp_rd_q[0]});
                        void'(exp_rd_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #20_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "time limit");
    end

    initial begin : stim
        logic [4:0]  ph;
        logic [4:0]  ra;
        logic [15:0] wd;
        bit          rd;
        model_reset();
        #100;
        check("rst_oe", {31'd0, mdio_oe}, 32'd0);
        check("rst_mdio_o", {31'd0, mdio_o}, 32'd0);
        check("rst_wr_pulse", {31'd0, reg_wr_pulse}, 32'd0);
        check("rst_wr_addr", {27'd0, reg_wr_addr}, 32'd0);
        check("rst_wr_data", {16'd0, reg_wr_data}, 32'd0);
        check("rst_cfg_bmcr", {16'd0, cfg_bmcr}, {16'd0, D0});
        @(negedge clk);
        rst_n = 1'b1;
        #200;

        // Read ANAR default, write BMCR.
        frame(1'b1, PHY, 5'd4, 16'h0000, 32, -1);
        frame(1'b0, PHY, 5'd0, 16'h3100, 32, -1);
        // Foreign PHY address, then a valid ID1 read.
        frame(1'b1, 5'd2, 5'd0, 16'h0000, 32, -1);
        frame(1'b1, PHY, 5'd2, 16'h0000, 32, -1);
        // Short preamble: write must be ignored.
        frame(1'b0, PHY, 5'd0, 16'h1234, 31, -1);
        // ANAR write, then BMCR soft reset restores both.
        frame(1'b0, PHY, 5'd4, 16'h0061, 32, -1);
        frame(1'b1, PHY, 5'd4, 16'h0000, 32, -1);
        frame(1'b0, PHY, 5'd0, 16'h8000, 32, -1);
        frame(1'b1, PHY, 5'd4, 16'h0000, 32, -1);
        frame(1'b1, PHY, 5'd0, 16'h0000, 32, -1);
        // Reset in the middle of a read, then full frames again.
        frame(1'b0, PHY, 5'd4, 16'h0ABC, 32, -1);
        frame(1'b1, PHY, 5'd0, 16'h0000, 32, 7);
        frame(1'b1, PHY, 5'd4, 16'h0000, 32, -1);
        frame(1'b1, PHY, 5'd3, 16'h0000, 33, -1);
        frame(1'b1, PHY, 5'd1, 16'h0000, 32, -1);

        for (int n = 0; n < 30; n++) begin
            rd = $urandom_range(0, 1) == 1;
            ph = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(2, 31)) : PHY;
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            wd = 16'($urandom);
            if (ra == 5'd0 && $urandom_range(0, 3) != 0) wd[15] = 1'b0;
            frame(rd, ph, ra, wd, 32 + $urandom_range(0, 3), -1);
        end

        #1000;
        check("rd_queue_drained", exp_rd_q.size(), 32'd0);
        check("wr_queue_drained", exp_wr_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/phy_mdio_responder.md
PHY_MDIO_RESPONDER -- requirements
Module: phy_mdio_responder

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  PHY_ADDR, 5'h01, PHY address this responder answers;
  PREAMBLE_LEN, 32, minimum consecutive 1 bits before ST;
  REG0_DEF, 16'h1140, BMCR reset value;
  REG1_DEF, 16'h7809, BMSR value (read-only);
  REG2_DEF, 16'h0022, PHY ID1 (read-only);
  REG3_DEF, 16'h1622, PHY ID2 (read-only);
  REG4_DEF, 16'h01E1, ANAR reset value.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  system clock; single clock domain;
  rst_n  in  1  asynchronous active-low reset;
  phy_mdc  in  1  MDC from station manager, asynchronous to clk;
  mdio_i  in  1  MDIO pad input;
  mdio_o  out  1  MDIO drive value;
  mdio_oe  out  1  MDIO output enable (1 = drive);
  cfg_bmcr  out  16  current register 0 contents;
  reg_wr_pulse  out  1  one-clk strobe per committed write;
  reg_wr_addr  out  5  register address of the committed write;
  reg_wr_data  out  16  data of the committed write.

Function
REQ-003 phy_mdc and mdio_i SHALL each pass a 2-flop synchronizer; an MDC rising edge SHALL be detected on the synchronized value, and all frame bits SHALL be sampled from synchronized MDIO on that detected edge.
REQ-004 The frame SHALL be IEEE 802.3 Clause 22: preamble, ST=01, OP (10 read, 01 write), PHYAD[4:0], REGAD[4:0], TA[1:0], DATA[15:0], all MSB first.
REQ-005 The FSM SHALL have states PREAMBLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, with a 5-bit bit counter.
REQ-006 PREAMBLE: count consecutive sampled 1s, saturating; a 0 after at least PREAMBLE_LEN ones SHALL enter ST (as ST bit 0); a 0 earlier SHALL clear the count.
REQ-007 ST second bit not 1, or OP 00/11, SHALL return to PREAMBLE with the count cleared.
REQ-008 A PHYAD not equal to PHY_ADDR SHALL abort to PREAMBLE; mdio_oe SHALL stay 0 for the whole frame.
REQ-009 Read: on the detected edge sampling TA bit 1, assert mdio_oe with mdio_o=0 within 1 clk. On each following edge, present the next data bit D15..D0. On the edge sampling D0, deassert mdio_oe. Then return to PREAMBLE.
REQ-010 Read data SHALL be latched at the end of REGAD. Reg 0 and 4 SHALL read their current value, regs 1-3 their parameter value, and regs 5-31 0x0000.
REQ-011 Write: TA bits SHALL be sampled but not checked. After D0 is sampled, regs 0 and 4 SHALL update and reg_wr_pulse SHALL be 1 for exactly one clk, carrying the address and data. Writes to other addresses SHALL pulse but change no state.
REQ-012 A write to reg 0 with bit 15 set SHALL restore regs 0 and 4 to defaults in the same cycle; bit 15 SHALL always read 0.
REQ-013 A new preamble SHALL be accepted immediately after any frame end or abort; no idle gap is required.

Reset
REQ-014 rst_n low SHALL asynchronously force mdio_oe=0, mdio_o=0, reg_wr_pulse=0, reg_wr_addr=0, reg_wr_data=0, cfg_bmcr=REG0_DEF, reg 4=REG4_DEF, synchronizers=1, FSM=PREAMBLE, and all counters to 0, including in the middle of a frame.
REQ-015 After rst_n rises, a full preamble SHALL be required before any frame is accepted.

Structure
REQ-016 Opcode constants, register address constants and the FSM state encoding SHALL live in a shared package mdio_pkg, which the station-manager side also uses.
REQ-017 The synchronizer plus edge detector SHALL be one sub-module, mdio_sync_edge, instantiated for MDC and MDIO; the remaining logic SHALL be flat.

Verification
REQ-018 The bench SHALL drive MDC at 2.5 MHz from a 25 MHz clk, with MDIO as an open-drain pullup resolved from mdio_oe/mdio_o.
REQ-019 Write PHYAD 1, REGAD 0, data 0x3100 -> cfg_bmcr=0x3100; one reg_wr_pulse with addr 0 and data 0x3100.
REQ-020 Read PHYAD 1, REGAD 4 after reset -> TA bit 2 driven 0; data 0x01E1 serialized; mdio_oe low after D0.
REQ-021 Read PHYAD 2 -> mdio_oe never asserts; a following valid read of REGAD 2 returns 0x0022.
REQ-022 Preamble of 31 ones then a valid write -> ignored, no reg_wr_pulse, cfg_bmcr unchanged.
REQ-023 Write reg 0 with 0x8000 after writing reg 4 with 0x0061 -> reg 4 reads 0x01E1 and reg 0 reads 0x1140.
REQ-024 rst_n low at data bit 8 of a read -> mdio_oe=0 in the same cycle; the next full frame completes correctly.
